// File: rtl/div_3b_seq_pkg.sv
// Shared constants and state encoding for the
// sequential restoring divider.
package div_3b_seq_pkg;
  localparam int WIDTH = 3;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_3b_seq_bla.sv
// bla_sub: N-bit borrow-lookahead subtractor, a - b.
// Ports: a, b (N) in; diff (N), borrow (a < b) out.
module bla_sub #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         acc;
  logic         pp;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Each carry is a flat sum of generate terms
  // gated by the propagate run above them; the
  // carry-in of 1 completes a + ~b + 1.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b1;
    c[0] = 1'b1;
    for (int i = 1; i <= N; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i] = acc | pp;
    end
  end

  assign diff   = p ^ c[N-1:0];
  assign borrow = ~c[N];

endmodule

// File: rtl/div_3b_seq.sv
// div_3b_seq: restoring divider, one quotient bit per clock.
// Ports: clk, rst_n, start, A, B in; busy, done, Q, R, div_by_zero out.
module div_3b_seq
  import div_3b_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] quo_nxt;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             accept;
  logic             b_zero;

  assign shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};

  bla_sub #(
    .N(WIDTH + 1)
  ) u_sub (
    .a     (shifted),
    .b     ({1'b0, dvs}),
    .diff  (diff),
    .borrow(borrow)
  );

  assign rem_nxt = borrow ? shifted : diff;
  assign quo_nxt = {quo[WIDTH-2:0], ~borrow};
  assign accept  = (state == IDLE) && start;
  assign b_zero  = (B == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (start)
          state_nxt = b_zero ? DONE : CALC;
      end
      (state == CALC): begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      (state == DONE): begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (b_zero) begin
        Q           <= '1;
        R           <= A;
        div_by_zero <= 1'b1;
      end else begin
        dvd <= A;
        dvs <= B;
        rem <= '0;
        quo <= '0;
        cnt <= CNT_W'(WIDTH - 1);
      end
    end else if (state == CALC) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        // Remainder is below the divisor, so
        // its top bit is always clear here.
        Q           <= quo_nxt;
        R           <= rem_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_3b_seq.sv
// Scoreboard bench for div_3b_seq: expected results
// queued at start, compared when done pulses.
module tb_div_3b_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] A = '0;
  logic [2:0] B = '0;
  logic       busy;
  logic       done;
  logic [2:0] Q;
  logic [2:0] R;
  logic       div_by_zero;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;

  typedef struct {
    logic [2:0] q;
    logic [2:0] r;
    logic       dbz;
    int         t;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  div_3b_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic push(
    input logic [2:0] a,
    input logic [2:0] b,
    input int         t
  );
    exp_t e;
    if (b == 3'd0) begin
      e.q   = 3'd7;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    e.t = t;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        chk("unexp_done", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("q", 32'(Q), 32'(mon_e.q));
        chk("r", 32'(R), 32'(mon_e.r));
        chk("dbz", 32'(div_by_zero),
            32'(mon_e.dbz));
        chk("done_cyc", cyc, mon_e.t);
      end
    end
  end

  task automatic wait_empty(input int lim);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < lim) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sbq.size() != 0) begin
      chk("timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic run_op(
    input logic [2:0] a,
    input logic [2:0] b
  );
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    push(a, b, cyc + ((b == 3'd0) ? 1 : 4));
    @(negedge clk);
    start = 1'b0;
    chk("busy_c1", 32'(busy), 32'd1);
    wait_empty(12);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    // basic and boundary cases
    run_op(3'd7, 3'd2);
    run_op(3'd5, 3'd0);
    run_op(3'd6, 3'd3);
    run_op(3'd2, 3'd5);
    run_op(3'd7, 3'd1);

    // start held high: one accept per 5 cycles
    @(negedge clk);
    A     = 3'd6;
    B     = 3'd4;
    start = 1'b1;
    t0    = cyc;
    for (int k = 0; k < 3; k++)
      push(3'd6, 3'd4, t0 + 4 + 5 * k);
    repeat (14) @(negedge clk);
    start = 1'b0;
    wait_empty(6);
    repeat (3) @(negedge clk);
    chk("held_idle", 32'(busy), 32'd0);

    // reset in cycle 2 of 7/3
    @(negedge clk);
    A     = 3'd7;
    B     = 3'd3;
    start = 1'b1;
    push(3'd7, 3'd3, cyc + 4);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sbq.pop_back());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(Q), 32'd0);
    chk("abort_r", 32'(R), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    run_op(3'd7, 3'd3);

    // exhaustive sweep
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        run_op(3'(a), 3'(b));

    repeat (3) @(negedge clk);
    chk("sb_left", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_3b_seq.md
# div_3b_seq

Sequential restoring divider, the inverse operation to the team's 3-bit carry-lookahead adder. It accepts an unsigned dividend and divisor on a start pulse and iterates one quotient bit per clock through a lookahead subtractor. It returns quotient and remainder with a one-cycle done pulse. It sits beside the adder in the lab ALU datapath as its multi-cycle arithmetic unit.

## Interface
- WIDTH, 3, operand width in bits; Q is WIDTH bits, R is WIDTH bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  dividend, unsigned
- B  in  WIDTH  divisor, unsigned
- busy  out  1  high in CALC and DONE
- done  out  1  one-cycle pulse, result valid
- Q  out  WIDTH  quotient
- R  out  WIDTH  remainder
- div_by_zero  out  1  set with done when B was 0; holds until next accepted start

## Operation
- States: IDLE, CALC, DONE.
- IDLE with start=1 and B!=0:
  - latch A into the dividend shift register and B into the divisor register
  - clear the partial remainder (WIDTH+1 bits)
  - set iteration counter to WIDTH-1
  - go to CALC
- IDLE with start=1 and B==0:
  - load Q=all ones, R=A, div_by_zero=1
  - go to DONE; no CALC cycles
- CALC iteration, one per cycle:
  - shift the partial remainder left, taking the dividend MSB in
  - subtract zero-extended B (WIDTH+1 bits) in the lookahead subtractor
  - no borrow: keep the difference and shift quotient bit 1 in
  - borrow: keep the shifted value (restore) and shift 0 in
  - decrement the counter; counter==0 at the end of an iteration goes to DONE
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- Q, R and div_by_zero update only when entering DONE. They hold their values otherwise, including across later IDLE cycles.
- start is ignored in CALC and DONE; it is not queued.
- A and B are don't-care after the accepting edge.
- Width rules:
  - the subtractor is WIDTH+1 bits wide; borrow-out = MSB of the difference under unsigned compare
  - the remainder is always < B and fits in WIDTH bits; upper bit dropped at output

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, Q=0, R=0, div_by_zero=0, counter=0, internal registers 0.
- Latency, with edge 0 being the edge that samples start:
  - B!=0: CALC during cycles 1..WIDTH, done high in cycle WIDTH+1 (cycle 4 for WIDTH=3)
  - B==0: done high in cycle 1
- busy rises in the cycle after edge 0 and falls with done.
- Throughput: a new start is accepted in the first IDLE cycle after done, i.e. WIDTH+2 cycles between back-to-back starts.
- rst_n asserted mid-operation aborts immediately to reset values. No done is produced for the aborted operation.

## Structure
- Shared include/package holds:
  - state encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2
  - the counter width constant, clog2 of WIDTH
- One sub-module: bla_sub, a parameterised borrow-lookahead subtractor.
  - Built as generate/propagate lookahead on A + ~B + 1.
  - Outputs difference and borrow.
  - Purely combinational; instantiated once in the CALC datapath.
- Top-level div_3b_seq holds the FSM, counter, shift registers and output registers.

## Test plan
- A=7, B=2, start one cycle -> done in cycle 4; Q=3, R=1, div_by_zero=0; busy high cycles 1-4.
- A=5, B=0 -> done in cycle 1; Q=7, R=5, div_by_zero=1. Then A=6, B=3 -> Q=2, R=0, div_by_zero cleared.
- A=2, B=5 -> Q=0, R=2; A=7, B=1 -> Q=7, R=0.
- Start held high continuously with A=6, B=4:
  - second start accepted only in the IDLE cycle after done
  - done pulses are exactly WIDTH+2 cycles apart; each gives Q=1, R=2
  - extra starts during busy change nothing
- rst_n pulsed low in cycle 2 of a 7/3 division -> all outputs 0 immediately, no done; the next 7/3 gives Q=2, R=1.
- Exhaustive sweep over all 64 (A,B) pairs at WIDTH=3 against a reference model: B!=0 gives Q=A/B and R=A%B; B==0 gives the div_by_zero result.
